// File: rtl/l2_writeback_buffer.sv
// Dirty-victim write-back FIFO between L2 and DRAM with address lookup and coalescing of unissued lines.
// Latency: a line pushed into an empty idle buffer raises aw_valid one cycle later; the drain is AW -> W -> B, one line at a time.
// Backpressure: wb_ready drops when all DEPTH entries are valid; AW/W hold stable until ready; the head leaves only on b_valid.
module l2_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 512,
  parameter int ADDR_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [LINE_W-1:0]        wb_data,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [LINE_W-1:0]        lookup_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     wr_err,
  output logic [ADDR_W-1:0]        aw_addr,
  output logic                     aw_valid,
  input  logic                     aw_ready,
  output logic [1:0]               aw_len,
  output logic [1:0]               aw_size,
  output logic [1:0]               aw_burst,
  output logic [LINE_W-1:0]        w_data,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [63:0]              w_strb,
  output logic                     w_last,
  input  logic                     b_valid,
  input  logic                     b_resp,
  output logic                     b_ready
);

  localparam int PW    = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - 6;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t              state, state_nxt;
  logic [TAG_W-1:0]    tag_q  [DEPTH];
  logic [LINE_W-1:0]   data_q [DEPTH];
  logic [DEPTH-1:0]    vld_q;
  logic [PW-1:0]       head, tail;

  logic [TAG_W-1:0]    wb_tag, lk_tag;
  logic                push, pop, locked;
  logic                co_hit;
  logic [PW-1:0]       co_idx, wr_idx;
  logic                unused_low_bits;

  assign wb_tag = wb_addr[ADDR_W-1:6];
  assign lk_tag = lookup_addr[ADDR_W-1:6];
  assign unused_low_bits = ^{wb_addr[5:0], lookup_addr[5:0]};

  // Ready depends only on registered occupancy so a same-cycle pop never feeds back into the L2.
  assign wb_ready = !reset && (occupancy < DEPTH_C);
  assign push     = wb_valid && wb_ready;
  assign pop      = (state == S_B) && b_valid;
  assign locked   = (state != S_IDLE);

  // Find an unlocked entry holding the pushed line; the in-flight head is never rewritten.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (tag_q[i] == wb_tag) && !(locked && (PW'(i) == head))) begin
        co_hit = 1'b1;
        co_idx = PW'(i);
      end
    end
    wr_idx = co_hit ? co_idx : tail;
  end

  // Lookup: take the head if it matches, then let any newer match override it.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    if (vld_q[head] && (tag_q[head] == lk_tag)) begin
      lookup_hit  = 1'b1;
      lookup_data = data_q[head];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (tag_q[i] == lk_tag) && (PW'(i) != head)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[i];
      end
    end
  end

  // Control state: pointers, valid bits, occupancy, sticky error and drain state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      head      <= '0;
      tail      <= '0;
      vld_q     <= '0;
      occupancy <= '0;
      wr_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push && !co_hit) begin
        vld_q[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + PW'(1);
        if (b_resp) wr_err <= 1'b1;
      end
      case ({push && !co_hit, pop})
        2'b10:   occupancy <= occupancy + (PW+1)'(1);
        2'b01:   occupancy <= occupancy - (PW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Line storage; contents are qualified by vld_q so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      tag_q[wr_idx]  <= wb_tag;
      data_q[wr_idx] <= wb_data;
    end
  end

  // Drain FSM: one AW, one W beat, then wait for the B response before popping.
  always_comb begin
    state_nxt = state;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    case (state)
      S_IDLE: if (occupancy != '0) state_nxt = S_AW;
      S_AW: begin
        aw_valid = 1'b1;
        if (aw_ready) state_nxt = S_W;
      end
      S_W: begin
        w_valid = 1'b1;
        if (w_ready) state_nxt = S_B;
      end
      S_B: begin
        b_ready = 1'b1;
        if (b_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign aw_addr  = aw_valid ? {tag_q[head], 6'b0} : '0;
  assign w_data   = w_valid ? data_q[head] : '0;
  assign w_last   = w_valid;
  assign aw_len   = 2'b00;
  assign aw_size  = 2'b11;
  assign aw_burst = 2'b01;
  assign w_strb   = '1;

endmodule

// File: doc/l2_writeback_buffer.md
Name: l2_writeback_buffer

Overview:
- Sits directly downstream of L2Cache on the DRAM write path.
- Accepts dirty victim lines from the L2 over a valid/ready push port and holds them in a small FIFO. Drains them to DRAM one at a time as an AW → W → B sequence.
- Provides a combinational address lookup so an L2 read miss can forward a line that is still queued and has not yet been written to DRAM.
- Coalesces a second write to a line that is already queued and not yet issued.

Parameters:
- DEPTH, 4, number of line entries; power of 2, ≥ 2.
- LINE_W, 512, line width in bits (64 B).
- ADDR_W, 32, byte-address width.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- wb_valid  in  1  L2 presents a victim line.
- wb_ready  out  1  buffer can accept a line.
- wb_addr  in  ADDR_W  victim byte address; bits [5:0] ignored.
- wb_data  in  LINE_W  victim line data.
- lookup_addr  in  ADDR_W  L2 miss address to probe; bits [5:0] ignored.
- lookup_hit  out  1  a queued entry matches lookup_addr.
- lookup_data  out  LINE_W  data of the matching entry; 0 when no hit.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.
- wr_err  out  1  sticky; set on any error write response.
- aw_addr  out  ADDR_W  write address; line-aligned, bits [5:0] = 0.
- aw_valid  out  1  write address valid.
- aw_ready  in  1  DRAM accepts address.
- aw_len  out  2  constant 2'b00 (single beat).
- aw_size  out  2  constant 2'b11 (full line).
- aw_burst  out  2  constant 2'b01 (INCR).
- w_data  out  LINE_W  line data.
- w_valid  out  1  write data valid.
- w_ready  in  1  DRAM accepts data.
- w_strb  out  64  constant all ones.
- w_last  out  1  equals w_valid (single beat).
- b_valid  in  1  DRAM write response valid.
- b_resp  in  1  0 = OKAY, 1 = error.
- b_ready  out  1  buffer accepts response.

Behaviour:
Reset:
- While reset is high, and after it is released: FIFO empty, head/tail pointers 0, occupancy 0, state IDLE.
- aw_valid, w_valid, b_ready, lookup_hit, wr_err all 0; aw_addr, w_data, lookup_data all 0.
- wb_ready is forced 0 while reset is asserted.
- Reset mid-transaction discards all entries and any in-flight write with no recovery.

Push side:
- wb_ready = !reset && (occupancy < DEPTH). It is registered-state only, with no combinational path from the same-cycle B pop.
- An accept occurs when wb_valid && wb_ready at a rising edge.
- Coalesce: if the accepted line address (addr[ADDR_W-1:6]) matches a valid entry that is not locked, overwrite that entry's data in place. Occupancy is unchanged.
- Otherwise write the entry at the tail, tail ← tail+1 mod DEPTH, occupancy +1.
- Locked entry: the head entry while state ≠ IDLE. A match against a locked entry allocates a new entry.
- At most one unlocked match can exist.

Drain FSM (IDLE, AW, W, B):
- IDLE: if occupancy > 0, go to AW on the next edge. The head is locked from entry into AW onward.
- AW: aw_valid = 1, aw_addr = head line address. Hold both stable until aw_ready. On aw_valid && aw_ready go to W.
- W: w_valid = w_last = 1, w_data = head data. Hold stable until w_ready. On w_valid && w_ready go to B.
- B: b_ready = 1. On b_valid:
  - Pop the head: head ← head+1 mod DEPTH, occupancy −1.
  - If b_resp = 1, set wr_err.
  - Go to IDLE. No retry.
- Latency: a line accepted at edge N into an empty, idle buffer gives aw_valid = 1 in the cycle after edge N+1. Best-case push-to-pop is 5 edges.
- Same-edge push and B pop: occupancy is unchanged, both pointers advance, and the full→not-full transition is visible the next cycle.

Lookup:
- Purely combinational over the entries valid at the start of the current cycle, including a locked head.
- A push accepted this cycle is visible to lookup from the next cycle.
- If both the locked head and a newer entry match, return the newer entry's data.
- lookup_hit = 0 ⇒ lookup_data = 0.

Wrap-around:
- Pointers are log2(DEPTH) bits and wrap naturally.
- Occupancy saturates neither up nor down; an underflow or overflow is a design error and the bench asserts on it.

Test Plan:
- Reset, then push line addr 0x1000 data 0xA5.. → exactly one AW (addr 0x1000), then one W (data 0xA5.., strb all 1s, last=1). B OKAY → occupancy 1→0, wr_err=0.
- Hold aw_ready=0 for 10 cycles, then w_ready=0 for 5 cycles → aw_addr and w_data stable throughout, no duplicate handshakes, occupancy stays 1.
- Push 4 distinct lines with b_valid held low → wb_ready=0 at occupancy 4. A 5th push stalls. A B response pops the head; the next cycle has wb_ready=1 and the 5th line is accepted at the tail (pointer wraps to 0).
- Queue 0x2000 (data X) behind an in-flight head, then push 0x2000 (data Y) → occupancy unchanged, lookup(0x2003) hit with data Y, DRAM receives Y once. Push 0x1000 while 0x1000 is the locked head → new entry allocated, lookup returns the newer data.
- B response with b_resp=1 → head popped, wr_err=1 and stays 1 through subsequent OKAY responses until reset.
- Assert reset during state W with 3 entries queued → all outputs 0 immediately, occupancy 0, and no AW/W after reset is released until a new push.
